// File: rtl/vcrop.sv
// vcrop: crops a rectangular window out of an AXI-Stream video stream.
// The window (x_start, x_len, y_start, y_len) is latched on every
// start-of-frame beat. Beats inside the window pass through a single output
// register stage, and beats outside it are dropped. Beats that arrive before
// the first start-of-frame after reset are also dropped.
module vcrop #(
    parameter int DATA_WIDTH = 8,
    parameter int DIM_WIDTH  = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] s_axis_data_tdata,
    input  logic                  s_axis_data_tvalid,
    output logic                  s_axis_data_tready,
    input  logic                  s_axis_data_tuser,
    input  logic                  s_axis_data_tlast,
    input  logic [DIM_WIDTH-1:0]  x_start,
    input  logic [DIM_WIDTH-1:0]  x_len,
    input  logic [DIM_WIDTH-1:0]  y_start,
    input  logic [DIM_WIDTH-1:0]  y_len,
    output logic [DATA_WIDTH-1:0] m_axis_data_tdata,
    output logic                  m_axis_data_tvalid,
    input  logic                  m_axis_data_tready,
    output logic                  m_axis_data_tuser,
    output logic                  m_axis_data_tlast,
    output logic                  short_line,
    output logic [15:0]           frame_count
);

    typedef enum logic {WAIT_SOF = 1'b0, ACTIVE = 1'b1} state_t;

    localparam logic [DIM_WIDTH-1:0] DIM_MAX  = '1;
    localparam logic [DIM_WIDTH-1:0] DIM_ONE  = {{(DIM_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DIM_WIDTH:0]   WIDE_ONE = {{DIM_WIDTH{1'b0}}, 1'b1};

    state_t                 state, state_nxt;
    logic                   active;
    logic                   s_acc, sof_acc, fwd_en, sof_pend;
    logic [DIM_WIDTH-1:0]   px, ln, xs_q, xl_q, ys_q, yl_q;
    logic [DIM_WIDTH-1:0]   cur_px, cur_ln, win_xs, win_xl, win_ys, win_yl;
    logic [DIM_WIDTH:0]     x_end, y_end, px_next_w;
    logic                   in_x, in_y, in_win, at_x_end;

    // Counter step that holds at all-ones instead of wrapping.
    function automatic logic [DIM_WIDTH-1:0] sat_inc(input logic [DIM_WIDTH-1:0] v);
        return (v == DIM_MAX) ? v : v + DIM_ONE;
    endfunction

    assign s_axis_data_tready = !m_axis_data_tvalid | m_axis_data_tready;
    assign s_acc   = s_axis_data_tvalid & s_axis_data_tready;
    assign sof_acc = s_acc & s_axis_data_tuser;

    // Coordinate and window of the current beat. A start-of-frame beat is
    // always (0,0) and is judged against the window presented with it.
    always_comb begin
        cur_px    = sof_acc ? '0 : px;
        cur_ln    = sof_acc ? '0 : ln;
        win_xs    = sof_acc ? x_start : xs_q;
        win_xl    = sof_acc ? x_len   : xl_q;
        win_ys    = sof_acc ? y_start : ys_q;
        win_yl    = sof_acc ? y_len   : yl_q;
        x_end     = {1'b0, win_xs} + {1'b0, win_xl};
        y_end     = {1'b0, win_ys} + {1'b0, win_yl};
        px_next_w = {1'b0, cur_px} + WIDE_ONE;
        in_x      = (cur_px >= win_xs) && ({1'b0, cur_px} < x_end);
        in_y      = (cur_ln >= win_ys) && ({1'b0, cur_ln} < y_end);
        in_win    = in_x && in_y;
        at_x_end  = (px_next_w == x_end);
        fwd_en    = s_acc && in_win && (active || sof_acc);
    end

    // Frame-tracking state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= WAIT_SOF;
        else        state <= state_nxt;
    end

    // Leave WAIT_SOF on the first accepted start-of-frame and stay in ACTIVE.
    always_comb begin
        state_nxt = state;
        if (state == WAIT_SOF && sof_acc) state_nxt = ACTIVE;
    end

    // Decoded state output.
    always_comb begin
        active = (state == ACTIVE);
    end

    // Pixel/line counters, window latch, SOF tracking and status.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            px          <= '0;
            ln          <= '0;
            xs_q        <= '0;
            xl_q        <= '0;
            ys_q        <= '0;
            yl_q        <= '0;
            sof_pend    <= 1'b0;
            short_line  <= 1'b0;
            frame_count <= '0;
        end else begin
            if (s_acc) begin
                if (s_axis_data_tlast) begin
                    px <= '0;
                    ln <= sat_inc(cur_ln);
                end else begin
                    px <= sat_inc(cur_px);
                    ln <= cur_ln;
                end
            end
            if (sof_acc) begin
                xs_q        <= x_start;
                xl_q        <= x_len;
                ys_q        <= y_start;
                yl_q        <= y_len;
                frame_count <= frame_count + 16'd1;
            end
            if (fwd_en)       sof_pend <= 1'b0;
            else if (sof_acc) sof_pend <= 1'b1;
            if (s_acc && in_win && s_axis_data_tlast && (px_next_w < x_end))
                short_line <= 1'b1;
        end
    end

    // Output register stage: it loads whenever it is empty or being drained.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_axis_data_tvalid <= 1'b0;
            m_axis_data_tdata  <= '0;
            m_axis_data_tuser  <= 1'b0;
            m_axis_data_tlast  <= 1'b0;
        end else if (s_axis_data_tready) begin
            m_axis_data_tvalid <= fwd_en;
            if (fwd_en) begin
                m_axis_data_tdata <= s_axis_data_tdata;
                m_axis_data_tuser <= sof_pend | sof_acc;
                m_axis_data_tlast <= at_x_end | s_axis_data_tlast;
            end
        end
    end

endmodule

// File: doc/vcrop.md
VCROP -- requirements
Module: vcrop

Interface
REQ-001 Parameter: DATA_WIDTH, 8, pixel width in bits.
REQ-002 Parameter: DIM_WIDTH, 12, width of coordinate counters and window config.
REQ-003 Port: clk  input  1  single clock for all logic.
REQ-004 Port: reset  input  1  asynchronous active-low reset.
REQ-005 Port: s_axis_data_tdata  input  DATA_WIDTH  pixel from the camera-sync stage.
REQ-006 Port: s_axis_data_tvalid  input  1  input beat valid.
REQ-007 Port: s_axis_data_tready  output  1  input beat accepted when high with tvalid.
REQ-008 Port: s_axis_data_tuser  input  1  start of frame; first pixel of frame.
REQ-009 Port: s_axis_data_tlast  input  1  end of line; last pixel of line.
REQ-010 Port: x_start, x_len, y_start, y_len  input  DIM_WIDTH each  crop window config.
REQ-011 Port: m_axis_data_tdata/tvalid/tready/tuser/tlast  out/out/in/out/out  DATA_WIDTH/1/1/1/1  cropped stream, same semantics as input.
REQ-012 Port: short_line  output  1  sticky flag: an input line ended inside the horizontal window.
REQ-013 Port: frame_count  output  16  number of input SOF beats accepted, wrapping.

Function
REQ-014 Output is a single register stage: s_axis_data_tready = !m_axis_data_tvalid | m_axis_data_tready; no combinational path from s tvalid to m tvalid.
REQ-015 Input beat is accepted when s tvalid & s tready; only accepted beats advance counters.
REQ-016 Accepted in-window beat appears on m_axis_data_* on the next clk edge (latency 1); m tvalid holds with stable data until m tready.
REQ-017 Counters px (pixel) and ln (line), DIM_WIDTH bits: on accepted tuser beat the beat is coordinate (0,0); afterwards px increments per beat, and on a tlast beat px returns to 0 and ln increments.
REQ-018 px and ln saturate at all-ones and never wrap.
REQ-019 x_start, x_len, y_start, y_len are latched on each accepted tuser beat; the latched values govern the whole frame, including the tuser beat itself.
REQ-020 Beat is in window iff xs <= px < xs+xl and ys <= ln < ys+yl, with sums computed at DIM_WIDTH+1 bits (no overflow).
REQ-021 Beats outside the window are accepted and discarded.
REQ-022 Output tlast = in window & (px == xs+xl-1 | input tlast).
REQ-023 Output tuser = 1 on the first forwarded beat after each accepted input tuser; the SOF-pending flag is set by input tuser and cleared when that beat is registered.
REQ-024 If input tlast occurs in window with px < xs+xl-1, set short_line; it stays set until reset.
REQ-025 x_len == 0 or y_len == 0 -> no beats forwarded for that frame.
REQ-026 Beats before the first tuser after reset are discarded (state WAIT_SOF); the first tuser moves the block to ACTIVE, which persists.
REQ-027 Input tuser mid-frame restarts counters at (0,0) and relatches the window; the partial frame is not padded.
REQ-028 frame_count increments on every accepted tuser beat and wraps 0xFFFF -> 0.

Reset
REQ-029 reset low asynchronously clears m tvalid, m tuser, m tlast, short_line, frame_count, px, ln, SOF-pending, and the latched window; state = WAIT_SOF; m tdata = 0.
REQ-030 s tready is 1 during and immediately after reset (output register empty).
REQ-031 Reset asserted mid-frame drops any held output beat; after release, output resumes only after the next tuser.

Verification
REQ-032 Bench: 8x4 frame, window xs=2, xl=3, ys=1, yl=2, m tready=1 -> 6 beats out (px 2-4 on lines 1-2); tuser on the first, tlast on the 3rd and 6th; frame_count=1.
REQ-033 Bench: same frame, m tready toggled 1010... -> identical output sequence, no beat lost or duplicated, tdata stable while stalled.
REQ-034 Bench: line 2 truncated to 3 pixels with xs=2, xl=3 -> output line of 1 beat with tlast; short_line=1.
REQ-035 Bench: 20 beats before any tuser, then a frame -> no output before the tuser; first output has tuser=1.
REQ-036 Bench: x_len=0 -> zero output beats, frame_count still increments; window xs=4094, xl=2 with DIM_WIDTH=12 -> no overflow, px 4094-4095 forwarded.
REQ-037 Bench: reset pulsed while m tvalid=1 and m tready=0 -> m tvalid=0 immediately, short_line=0, frame_count=0.
